// File: rtl/heater_driver.sv
// Heater output stage: dwell-time limited relay drive with latched over-temperature
// and (when HEATER_WDOG_EN is defined) stale-sensor watchdog faults.
module heater_driver #(
  parameter int         CNT_W       = 26,
  parameter int         MIN_ON_CYC  = 5_000_000,
  parameter int         MIN_OFF_CYC = 5_000_000,
  parameter logic [7:0] T_MAX       = 8'd250,
  parameter int         WDOG_CYC    = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       onOff,
  input  logic [7:0] tempReal,
  input  logic       tempStrobe,
  input  logic       faultClr,
  output logic       heater,
  output logic       fault,
  output logic [1:0] faultCode,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'b00,
    ST_ON    = 2'b01,
    ST_LOCK  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(MIN_ON_CYC - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(MIN_OFF_CYC - 1);

  // Degenerate dwell/watchdog lengths would break the counter compares.
  if (MIN_ON_CYC < 1 || MIN_OFF_CYC < 1 || WDOG_CYC < 2) begin : g_bad_params
    $error("heater_driver: illegal dwell or watchdog length");
  end

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] dwell_reg, dwell_next;
  logic [7:0]       last_temp_reg;
  logic             heater_reg;
  logic             fault_reg, fault_next;
  logic [1:0]       code_reg, code_next;
  logic             ot_evt;
  logic             wd_evt;
  logic             fault_exit;

  assign ot_evt = tempStrobe && (tempReal >= T_MAX);

  // Exit uses the temperature held before this cycle; a fresh over-temp blocks it.
  assign fault_exit = (state_reg == ST_FAULT) && faultClr &&
                      (last_temp_reg < T_MAX) && !ot_evt;

`ifdef HEATER_WDOG_EN
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYC - 1);

  logic [CNT_W-1:0] wdog_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_reg <= '0;
    end else if (tempStrobe || fault_exit) begin
      wdog_reg <= '0;
    end else if (wdog_reg != WDOG_LAST) begin
      wdog_reg <= wdog_reg + CNT_ONE;
    end
  end

  assign wd_evt = (wdog_reg == WDOG_LAST) && !tempStrobe;
`else
  assign wd_evt = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    dwell_next = dwell_reg;
    fault_next = fault_reg;
    code_next  = code_reg;
    if ((state_reg != ST_FAULT) && (ot_evt || wd_evt)) begin
      state_next = ST_FAULT;
      fault_next = 1'b1;
      code_next  = ot_evt ? 2'b01 : 2'b10;
    end else begin
      case (state_reg)
        ST_OFF: begin
          if (onOff) begin
            state_next = ST_ON;
            dwell_next = '0;
          end
        end
        ST_ON: begin
          // Counter parks at the last value so a long on-period cannot wrap it.
          if (dwell_reg == ON_LAST) begin
            if (!onOff) begin
              state_next = ST_LOCK;
              dwell_next = '0;
            end
          end else begin
            dwell_next = dwell_reg + CNT_ONE;
          end
        end
        ST_LOCK: begin
          if (dwell_reg == OFF_LAST) begin
            state_next = ST_OFF;
          end else begin
            dwell_next = dwell_reg + CNT_ONE;
          end
        end
        ST_FAULT: begin
          if (fault_exit) begin
            state_next = ST_LOCK;
            dwell_next = '0;
            fault_next = 1'b0;
            code_next  = 2'b00;
          end
        end
        default: begin
          state_next = ST_OFF;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_OFF;
      dwell_reg     <= '0;
      last_temp_reg <= 8'd0;
      heater_reg    <= 1'b0;
      fault_reg     <= 1'b0;
      code_reg      <= 2'b00;
    end else begin
      state_reg  <= state_next;
      dwell_reg  <= dwell_next;
      heater_reg <= (state_next == ST_ON);
      fault_reg  <= fault_next;
      code_reg   <= code_next;
      if (tempStrobe) begin
        last_temp_reg <= tempReal;
      end
    end
  end

  assign heater    = heater_reg;
  assign fault     = fault_reg;
  assign faultCode = code_reg;
  assign state     = state_reg;

endmodule

// File: tb/tb_heater_driver.sv
// Directed bench for heater_driver: dwell timing, over-temp latch/clear, watchdog, async reset.
module tb_heater_driver;

  localparam logic [5:0] OFF_V  = 6'b0_0_00_00;
  localparam logic [5:0] ON_V   = 6'b1_0_00_01;
  localparam logic [5:0] LOCK_V = 6'b0_0_00_10;
  localparam logic [5:0] FOT_V  = 6'b0_1_01_11;
  localparam logic [5:0] FWD_V  = 6'b0_1_10_11;

  logic       clk;
  logic       rst;
  logic       onOff;
  logic [7:0] tempReal;
  logic       tempStrobe;
  logic       faultClr;
  logic       heater;
  logic       fault;
  logic [1:0] faultCode;
  logic [1:0] state;

  int n_checks = 0;
  int n_pass   = 0;
  int gap      = 0;
  bit auto_strobe = 1'b1;

  heater_driver #(
    .CNT_W      (26),
    .MIN_ON_CYC (8),
    .MIN_OFF_CYC(6),
    .T_MAX      (8'd200),
    .WDOG_CYC   (100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .onOff     (onOff),
    .tempReal  (tempReal),
    .tempStrobe(tempStrobe),
    .faultClr  (faultClr),
    .heater    (heater),
    .fault     (fault),
    .faultCode (faultCode),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] obs();
    return {heater, fault, faultCode, state};
  endfunction

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got {heater,fault,code,state}=%b expected %b", tag, got, exp);
  endtask

  // One clock; inputs change 1 ns after the edge. Background strobe every 20 cycles.
  task automatic step();
    @(posedge clk);
    #1;
    tempStrobe = 1'b0;
    if (auto_strobe) begin
      gap = gap + 1;
      if (gap >= 20) begin
        tempStrobe = 1'b1;
        tempReal   = 8'd25;
        gap        = 0;
      end
    end
  endtask

  task automatic strobe(input logic [7:0] t);
    tempStrobe = 1'b1;
    tempReal   = t;
    gap        = 0;
    step();
  endtask

  initial begin
    rst = 1'b1; onOff = 1'b0; tempReal = 8'd0; tempStrobe = 1'b0; faultClr = 1'b0;
    #1;
    check("reset", obs(), OFF_V);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    gap = 0;
    step();
    check("idle_off", obs(), OFF_V);

    // One-cycle demand pulse: 8 cycles on, 6 cycles lock, then off.
    onOff = 1'b1;
    step();
    onOff = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("s1_on%0d", i), obs(), ON_V);
      step();
    end
    for (int i = 0; i < 6; i++) begin
      check($sformatf("s1_lock%0d", i), obs(), LOCK_V);
      step();
    end
    check("s1_off", obs(), OFF_V);

    // Demand held high through LOCK is not honoured until OFF.
    onOff = 1'b1;
    step();
    check("s2_on", obs(), ON_V);
    repeat (7) step();
    check("s2_on_min", obs(), ON_V);
    onOff = 1'b0;
    step();
    check("s2_lock_entry", obs(), LOCK_V);
    onOff = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("s2_lock%0d", i), obs(), LOCK_V);
      step();
    end
    check("s2_off", obs(), OFF_V);
    step();
    check("s2_reon", obs(), ON_V);

    // Over-temperature while ON, mid-dwell.
    strobe(8'd200);
    check("s3_ot_fault", obs(), FOT_V);
    onOff = 1'b0;
    faultClr = 1'b1;
    step();
    check("s3_clr_hot", obs(), FOT_V);
    faultClr = 1'b0;
    strobe(8'd150);
    check("s3_cool_noclr", obs(), FOT_V);
    faultClr = 1'b1;
    step();
    check("s3_clr_exit", obs(), LOCK_V);
    faultClr = 1'b0;
    repeat (6) step();
    check("s3_back_off", obs(), OFF_V);

    // Fresh over-temp in the same cycle as the clear blocks the exit.
    strobe(8'd210);
    check("s6_ot_from_off", obs(), FOT_V);
    strobe(8'd150);
    check("s6_cooled", obs(), FOT_V);
    faultClr = 1'b1;
    strobe(8'd210);
    check("s6_clr_blocked", obs(), FOT_V);
    faultClr = 1'b0;
    strobe(8'd100);
    faultClr = 1'b1;
    step();
    check("s6_clr_exit", obs(), LOCK_V);
    faultClr = 1'b0;
    repeat (6) step();
    check("s6_back_off", obs(), OFF_V);

    // Watchdog: gap 99 tolerated, gap 100 faults.
    auto_strobe = 1'b0;
    strobe(8'd25);
`ifdef HEATER_WDOG_EN
    repeat (98) step();
    check("s4_gap98", obs(), OFF_V);
    strobe(8'd25);
    check("s4_gap99_ok", obs(), OFF_V);
    repeat (99) step();
    check("s4_gap99_cnt", obs(), OFF_V);
    step();
    check("s4_gap100_fault", obs(), FWD_V);
    faultClr = 1'b1;
    step();
    check("s4_clr_exit", obs(), LOCK_V);
    faultClr = 1'b0;
`else
    repeat (150) step();
    check("s4_wdog_absent", obs(), OFF_V);
`endif
    auto_strobe = 1'b1;
    gap = 0;
    repeat (6) step();
    check("s4_resume_off", obs(), OFF_V);

    // Asynchronous reset in the middle of an ON period.
    onOff = 1'b1;
    step();
    onOff = 1'b0;
    step();
    check("s5_on", obs(), ON_V);
    #3;
    rst = 1'b1;
    #1;
    check("s5_rst_async", obs(), OFF_V);
    #1;
    rst = 1'b0;
    gap = 0;
    step();
    check("s5_after_rst", obs(), OFF_V);
    onOff = 1'b1;
    step();
    onOff = 1'b0;
    check("s5_resume_on", obs(), ON_V);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
